// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Size encodings, FSM states and the request legality check.
package mem_access_ctrl_pkg;

    localparam int MEM_WORDS_DEF = 512;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Misalignment, reserved size or out-of-range word index.
    function automatic logic access_err(input size_e size, input logic [1:0] lane, input logic oor);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad | oor;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response handshake of the data-memory access controller.
// master = pipeline (initiates requests), slave = controller.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_ctrl_lane_unit.sv
// Combinational byte/halfword lane logic: load extract+extend and store merge.
// Shared with the data-cache path, so it carries no state.
module mem_lane_unit
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sgn,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select, extension and read-modify-write merge.
    always_comb begin
        byte_s    = word[{lane, 3'b000} +: 8];
        half_s    = word[{lane[1], 4'b0000} +: 16];
        load_data = 32'h0000_0000;
        merged    = word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sgn & byte_s[7]}}, byte_s};
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sgn & half_s[15]}}, half_s};
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_WORD: begin
                load_data = word;
                merged    = wdata;
            end
            default: begin
                load_data = 32'h0000_0000;
                merged    = word;
            end
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: byte/half/word loads and stores over a word-addressed
// memory, with sub-word stores done as read-modify-write. Moore outputs only.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int ADDR_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_ctrl_if.slave   bus,
    output logic [31:0]        mem_dir,
    output logic [31:0]        mem_data_input,
    output logic               mem_rd,
    output logic               mem_wd,
    input  logic [31:0]        mem_data_output
);
    state_e            state_r;
    logic [ADDR_W-1:0] addr_r;
    size_e             size_r;
    logic              we_r;
    logic              signed_r;
    logic [31:0]       wdata_r;
    logic [31:0]       resp_rdata_r;
    logic              resp_err_r;
    logic [31:0]       mem_data_input_r;

    logic              oor_s;
    logic              req_err_s;
    size_e             req_size_s;
    logic [31:0]       load_data_s;
    logic [31:0]       merged_s;

    assign req_size_s = size_e'(bus.req_size);
    assign oor_s      = ({2'b00, bus.req_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));
    assign req_err_s  = access_err(req_size_s, bus.req_addr[1:0], oor_s);

    mem_lane_unit u_lane (
        .word      (mem_data_output),
        .wdata     (wdata_r),
        .lane      (addr_r[1:0]),
        .size      (size_r),
        .sgn       (signed_r),
        .load_data (load_data_s),
        .merged    (merged_s)
    );

    // Request capture, FSM sequencing and registered response/write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            addr_r           <= '0;
            size_r           <= SZ_BYTE;
            we_r             <= 1'b0;
            signed_r         <= 1'b0;
            wdata_r          <= 32'h0000_0000;
            resp_rdata_r     <= 32'h0000_0000;
            resp_err_r       <= 1'b0;
            mem_data_input_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        addr_r           <= bus.req_addr;
                        size_r           <= req_size_s;
                        we_r             <= bus.req_we;
                        signed_r         <= bus.req_signed;
                        wdata_r          <= bus.req_wdata;
                        mem_data_input_r <= bus.req_wdata;
                        resp_rdata_r     <= 32'h0000_0000;
                        resp_err_r       <= req_err_s;
                        if (req_err_s) begin
                            state_r <= ST_RESP;
                        end else if (bus.req_we && (req_size_s == SZ_WORD)) begin
                            state_r <= ST_WR;
                        end else begin
                            state_r <= ST_RD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    // Sub-word stores pass through here to fetch the old word.
                    if (we_r) begin
                        mem_data_input_r <= merged_s;
                        state_r          <= ST_WR;
                    end else begin
                        resp_rdata_r <= load_data_s;
                        state_r      <= ST_RESP;
                    end
                end
                ST_WR: begin
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.resp_valid = (state_r == ST_RESP);
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign mem_rd         = (state_r == ST_RD);
    assign mem_wd         = (state_r == ST_WR);
    assign mem_dir        = 32'({2'b00, addr_r[ADDR_W-1:2]});
    assign mem_data_input = mem_data_input_r;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a 512-word memory model.
module tb_mem_access_ctrl;
    logic        clk;
    logic        rst_n;
    logic [31:0] mem_dir;
    logic [31:0] mem_data_input;
    logic        mem_rd;
    logic        mem_wd;
    logic [31:0] mem_data_output;
    logic [31:0] mem [0:511];
    int          tests_run;
    int          tests_failed;
    int          overlap;

    mem_access_ctrl_if #(.ADDR_W(32)) bus ();

    mem_access_ctrl #(.MEM_WORDS(512), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .mem_dir         (mem_dir),
        .mem_data_input  (mem_data_input),
        .mem_rd          (mem_rd),
        .mem_wd          (mem_wd),
        .mem_data_output (mem_data_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge.
    assign mem_data_output = (mem_dir < 32'd512) ? mem[mem_dir[8:0]] : 32'h0000_0000;
    always @(posedge clk) begin
        if (mem_wd && (mem_dir < 32'd512)) mem[mem_dir[8:0]] <= mem_data_input;
    end

    always @(negedge clk) begin
        if (mem_rd && mem_wd) overlap++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int exp_lat, input int exp_rd, input int exp_wd,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           output logic [31:0] wdir, output logic [31:0] wdat);
        int lat;
        int rd_cnt;
        int wd_cnt;
        logic rdy;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_signed = sgn;
        bus.req_addr = addr; bus.req_wdata = wd;
        rdy = bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0; bus.req_addr = 32'hFFFF_FFFC; bus.req_wdata = 32'h0BAD_0BAD;
        lat = 0; rd_cnt = 0; wd_cnt = 0; wdir = 32'h0; wdat = 32'h0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (mem_rd) rd_cnt++;
            if (mem_wd) begin
                wd_cnt++;
                wdir = mem_dir;
                wdat = mem_data_input;
            end
            if (bus.resp_valid) break;
        end
        check_val({tag, "_ready"}, 32'(rdy), 32'd1);
        check_val({tag, "_lat"}, lat, exp_lat);
        check_val({tag, "_rdcyc"}, rd_cnt, exp_rd);
        check_val({tag, "_wdcyc"}, wd_cnt, exp_wd);
        check_val({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
        check_val({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] wdir;
        logic [31:0] wdat;
        logic [31:0] held;
        int          stray;
        tests_run = 0; tests_failed = 0; overlap = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0000_0000;
        mem[1]   = 32'h0102_0304;
        mem[2]   = 32'h1122_3344;
        mem[3]   = 32'h80FF_7F01;
        mem[64]  = 32'hA5A5_A5A5;
        mem[511] = 32'hCAFE_F00D;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;

        #12;
        check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_val("rst_mem_rd", 32'(mem_rd), 32'd0);
        check_val("rst_mem_wd", 32'(mem_wd), 32'd0);
        check_val("rst_mem_dir", mem_dir, 32'h0);
        check_val("rst_mem_din", mem_data_input, 32'h0);
        check_val("rst_rdata", bus.resp_rdata, 32'h0);
        check_val("rst_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Word store then load back.
        run_req("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 0, 1, 32'h0, 1'b0, wdir, wdat);
        check_val("st_word_dir", wdir, 32'd4);
        check_val("st_word_din", wdat, 32'hDEAD_BEEF);
        check_val("st_word_mem", mem[4], 32'hDEAD_BEEF);
        run_req("ld_word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1, 0, 32'hDEAD_BEEF, 1'b0, wdir, wdat);

        // Byte/half loads with sign and zero extension.
        run_req("ld_b_e_s", 1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 2, 1, 0, 32'hFFFF_FFFF, 1'b0, wdir, wdat);
        run_req("ld_b_f_u", 1'b0, 2'b00, 1'b0, 32'h0F, 32'h0, 2, 1, 0, 32'h0000_0080, 1'b0, wdir, wdat);
        run_req("ld_b_c_s", 1'b0, 2'b00, 1'b1, 32'h0C, 32'h0, 2, 1, 0, 32'h0000_0001, 1'b0, wdir, wdat);
        run_req("ld_h_e_s", 1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 2, 1, 0, 32'hFFFF_80FF, 1'b0, wdir, wdat);
        run_req("ld_h_c_u", 1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, 2, 1, 0, 32'h0000_7F01, 1'b0, wdir, wdat);
        run_req("ld_last", 1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 2, 1, 0, 32'hCAFE_F00D, 1'b0, wdir, wdat);

        // Sub-word stores go through read-modify-write.
        run_req("st_byte", 1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_00AA, 3, 1, 1, 32'h0, 1'b0, wdir, wdat);
        check_val("st_byte_dir", wdir, 32'd2);
        check_val("st_byte_din", wdat, 32'h1122_AA44);
        check_val("st_byte_mem", mem[2], 32'h1122_AA44);
        run_req("st_half", 1'b1, 2'b01, 1'b0, 32'h0A, 32'h1234_BEEF, 3, 1, 1, 32'h0, 1'b0, wdir, wdat);
        check_val("st_half_din", wdat, 32'hBEEF_AA44);
        check_val("st_half_mem", mem[2], 32'hBEEF_AA44);

        // Error requests: one-cycle response, no memory traffic.
        run_req("err_half", 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1, 0, 0, 32'h0, 1'b1, wdir, wdat);
        run_req("err_wst", 1'b1, 2'b10, 1'b0, 32'h102, 32'h1111_1111, 1, 0, 0, 32'h0, 1'b1, wdir, wdat);
        check_val("err_wst_mem", mem[64], 32'hA5A5_A5A5);
        run_req("err_rsvd", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 1, 0, 0, 32'h0, 1'b1, wdir, wdat);
        run_req("err_oor", 1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 1, 0, 0, 32'h0, 1'b1, wdir, wdat);

        // Backpressure: response held, new request ignored until back in IDLE.
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h10;
        @(posedge clk);
        #1;
        bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        check_val("bp_valid0", 32'(bus.resp_valid), 32'd1);
        held = bus.resp_rdata;
        check_val("bp_rdata0", held, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_valid", 32'(bus.resp_valid), 32'd1);
            check_val("bp_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
            check_val("bp_ready", 32'(bus.req_ready), 32'd0);
            check_val("bp_nowr", 32'(mem_wd), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check_val("bp_idle_valid", 32'(bus.resp_valid), 32'd0);
        check_val("bp_idle_ready", 32'(bus.req_ready), 32'd1);
        check_val("bp_idle_mem", mem[8], 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_val("bp_acc_wd", 32'(mem_wd), 32'd1);
        check_val("bp_acc_dir", mem_dir, 32'd8);
        @(negedge clk);
        check_val("bp_acc_resp", 32'(bus.resp_valid), 32'd1);
        check_val("bp_acc_mem", mem[8], 32'h1234_5678);
        @(negedge clk);

        // Reset while a byte store sits in WR.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 32'h04; bus.req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_val("rwr_rd", 32'(mem_rd), 32'd1);
        @(negedge clk);
        check_val("rwr_wd", 32'(mem_wd), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rwr_wd_drop", 32'(mem_wd), 32'd0);
        check_val("rwr_rd_drop", 32'(mem_rd), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("rwr_mem", mem[1], 32'h0102_0304);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid) stray++;
        end
        check_val("rwr_no_resp", stray, 32'd0);
        check_val("rwr_ready", 32'(bus.req_ready), 32'd1);
        run_req("rwr_ld", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 2, 1, 0, 32'h0102_0304, 1'b0, wdir, wdat);

        check_val("rd_wd_overlap", overlap, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
